// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> 32-bit instruction memory writes, CPU held in reset until a verified image.
// Latency: write strobe one cycle after a word's 4th byte; done/error one cycle after the closing byte.
// Backpressure: never stalls a byte; in_ready is high for the whole session (COUNT/DATA/CSUM), one byte per cycle max.
module imem_loader #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   // One extra bit so a word count of exactly DEPTH is representable.
   localparam int WW = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      DATA  = 3'd2,
      CSUM  = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [1:0]     byte_idx;
   logic [WW-1:0]  word_idx;
   logic [WW-1:0]  word_cnt;
   logic [7:0]     sum;
   logic [23:0]    lane_buf;

   logic           acc;
   logic           cnt_bad;
   logic           last_byte;
   logic           last_word;
   logic [7:0]     sum_fin;
   logic           sess_start;
   logic           sess_nxt;

   // Handshake and frame-position decodes used by both FSM and datapath.
   always_comb begin
      acc        = in_valid && in_ready;
      cnt_bad    = (in_data == 8'd0) || ({24'd0, in_data} > 32'(DEPTH));
      last_byte  = (byte_idx == 2'd3);
      last_word  = (word_idx == (word_cnt - WW'(1)));
      sum_fin    = sum + in_data;
      sess_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only honoured outside an active session.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = COUNT;
         COUNT: if (acc)   state_nxt = cnt_bad ? ERR : DATA;
         DATA:  if (acc && last_byte && last_word) state_nxt = CSUM;
         CSUM:  if (acc)   state_nxt = (sum_fin == 8'd0) ? DONE : ERR;
         DONE:  if (start) state_nxt = COUNT;
         ERR:   if (start) state_nxt = COUNT;
         default:          state_nxt = IDLE;
      endcase
   end

   assign sess_nxt = (state_nxt == COUNT) || (state_nxt == DATA) || (state_nxt == CSUM);

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         cpu_hold <= 1'b1;
      end else begin
         in_ready <= sess_nxt;
         busy     <= sess_nxt;
         done     <= (state_nxt == DONE);
         error    <= (state_nxt == ERR);
         cpu_hold <= (state_nxt != DONE);
      end
   end

   // Byte assembly, running checksum and memory write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx  <= 2'd0;
         word_idx  <= '0;
         word_cnt  <= '0;
         sum       <= 8'd0;
         lane_buf  <= 24'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (sess_start) begin
            byte_idx <= 2'd0;
            word_idx <= '0;
            sum      <= 8'd0;
         end
         if ((state == COUNT) && acc && !cnt_bad) begin
            word_cnt <= WW'(in_data);
         end
         if ((state == DATA) && acc) begin
            sum      <= sum_fin;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    lane_buf[7:0]   <= in_data;
               2'd1:    lane_buf[15:8]  <= in_data;
               2'd2:    lane_buf[23:16] <= in_data;
               default: begin
                  mem_we    <= 1'b1;
                  mem_wdata <= {in_data, lane_buf};
                  mem_addr  <= BASE_ADDR + 32'({word_idx, 2'b00});
                  word_idx  <= word_idx + WW'(1);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;

   logic        rdy0, we0, hold0, busy0, done0, err0;
   logic [31:0] addr0, wdata0;
   logic        rdy1, we1, hold1, busy1, done1, err1;
   logic [31:0] addr1, wdata1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] wa0[$];
   logic [31:0] wd0[$];
   int          wc0[$];
   logic [31:0] mem1[64];
   int          nw1 = 0;
   logic [31:0] last1 = 32'd0;

   imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
      .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0)
   );

   imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0100)) dut1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
      .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitors, sampled on the falling edge.
   always @(negedge clk) begin : mon
      logic [31:0] off;
      if (we0) begin
         wa0.push_back(addr0);
         wd0.push_back(wdata0);
         wc0.push_back(cyc);
      end
      if (we1) begin
         off = addr1 - 32'h100;
         if (off < 32'h100) mem1[off[7:2]] = wdata1;
         nw1++;
         last1 = addr1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic st);
      int n;
      n = 0;
      while (!rdy0 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         chk("ready_timeout", 32'd0, 32'd1);
      end else begin
         in_valid = 1'b1;
         in_data  = b;
         start    = st;
         tick();
         in_valid = 1'b0;
         start    = 1'b0;
      end
   endtask

   task automatic send_gap(input logic [7:0] b);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
      send(b, 1'b0);
   endtask

   logic [7:0]  f1[10];
   logic [31:0] words[64];
   logic [31:0] w;
   logic [7:0]  s;
   int          n0;

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      f1 = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h55, 8'h23, 8'h20, 8'h10, 8'h00, 8'h75};
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("rst_hold",  32'(hold0), 32'd1);
      chk("rst_ready", 32'(rdy0),  32'd0);
      chk("rst_busy",  32'(busy0), 32'd0);
      chk("rst_done",  32'(done0), 32'd0);
      chk("rst_error", 32'(err0),  32'd0);
      chk("rst_we",    32'(we0),   32'd0);
      chk("rst_addr",  addr0,      32'd0);
      chk("rst_wdata", wdata0,     32'd0);

      // Good two-word frame at full rate.
      n0 = wa0.size();
      pulse_start();
      chk("t1_busy",  32'(busy0), 32'd1);
      chk("t1_ready", 32'(rdy0),  32'd1);
      for (int i = 0; i < 10; i++) send(f1[i], 1'b0);
      chk("t1_nwr",   32'(wa0.size() - n0), 32'd2);
      if (wa0.size() - n0 >= 2) begin
         chk("t1_a0",  wa0[n0],     32'h0000_0000);
         chk("t1_d0",  wd0[n0],     32'h5550_0093);
         chk("t1_a1",  wa0[n0 + 1], 32'h0000_0004);
         chk("t1_d1",  wd0[n0 + 1], 32'h0010_2023);
         chk("t1_gap", 32'(wc0[n0 + 1] - wc0[n0]), 32'd4);
      end
      chk("t1_done",  32'(done0), 32'd1);
      chk("t1_hold",  32'(hold0), 32'd0);
      chk("t1_error", 32'(err0),  32'd0);
      chk("t1_idle",  32'(rdy0),  32'd0);

      // Same frame, bad checksum.
      n0 = wa0.size();
      pulse_start();
      chk("t2_done_clr", 32'(done0), 32'd0);
      chk("t2_hold",     32'(hold0), 32'd1);
      for (int i = 0; i < 9; i++) send(f1[i], 1'b0);
      send(8'h74, 1'b0);
      chk("t2_nwr",   32'(wa0.size() - n0), 32'd2);
      chk("t2_error", 32'(err0),  32'd1);
      chk("t2_done",  32'(done0), 32'd0);
      chk("t2_hold2", 32'(hold0), 32'd1);

      // Illegal counts.
      n0 = wa0.size();
      pulse_start();
      chk("t3_err_clr", 32'(err0), 32'd0);
      send(8'h00, 1'b0);
      chk("t3_err0",   32'(err0), 32'd1);
      chk("t3_rdy0",   32'(rdy0), 32'd0);
      pulse_start();
      send(8'h41, 1'b0);
      chk("t3_err65",  32'(err0), 32'd1);
      chk("t3_rdy65",  32'(rdy0), 32'd0);
      tick();
      chk("t3_nwr",    32'(wa0.size() - n0), 32'd0);

      // Full 64-word frame with gaps, checked on the BASE_ADDR=0x100 instance.
      for (int i = 0; i < 64; i++) begin
         words[i] = $urandom;
         mem1[i]  = 32'hxxxx_xxxx;
      end
      nw1 = 0;
      s   = 8'h00;
      pulse_start();
      send_gap(8'd64);
      for (int i = 0; i < 64; i++) begin
         w = words[i];
         for (int k = 0; k < 4; k++) begin
            s = s + w[8*k +: 8];
            send_gap(w[8*k +: 8]);
         end
      end
      send_gap(8'(8'd0 - s));
      chk("t4_nwr",  32'(nw1), 32'd64);
      chk("t4_last", last1,    32'h0000_01FC);
      chk("t4_done", 32'(done1), 32'd1);
      chk("t4_hold", 32'(hold1), 32'd0);
      for (int i = 0; i < 64; i++) chk("t4_mem", mem1[i], words[i]);

      // Reset mid-word, then a fresh frame with a stray start during DATA.
      n0 = wa0.size();
      pulse_start();
      send(8'h01, 1'b0);
      send(8'hEF, 1'b0);
      send(8'hBE, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rdy",  32'(rdy0),  32'd0);
      chk("t5_busy", 32'(busy0), 32'd0);
      chk("t5_hold", 32'(hold0), 32'd1);
      chk("t5_done", 32'(done0), 32'd0);
      chk("t5_we",   32'(we0),   32'd0);
      tick();
      chk("t5_nwr_rst", 32'(wa0.size() - n0), 32'd0);
      pulse_start();
      send(8'h01, 1'b0);
      send(8'hEF, 1'b1);
      send(8'hBE, 1'b0);
      send(8'hAD, 1'b0);
      send(8'hDE, 1'b0);
      send(8'hC8, 1'b0);
      chk("t5_nwr", 32'(wa0.size() - n0), 32'd1);
      if (wa0.size() > n0) begin
         chk("t5_addr", wa0[n0], 32'h0000_0000);
         chk("t5_data", wd0[n0], 32'hDEAD_BEEF);
      end
      chk("t5_done2", 32'(done0), 32'd1);
      chk("t5_hold2", 32'(hold0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
